// File: rtl/execute_alu_operand_ctrl_pkg.sv
// rtl/execute_alu_operand_ctrl_pkg.sv - Y86-64 icode constants, ALU function enum and width default
package y86_pkg;

    localparam int WIDTH_DEFAULT = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alufun_e;

endpackage

// File: rtl/execute_alu_operand_ctrl_if.sv
// rtl/execute_alu_operand_ctrl_if.sv - decode inputs and registered ALU operand outputs
interface execute_alu_operand_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             en;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [WIDTH-1:0] valC;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic [1:0]       alufun;
    logic             out_valid;

    // Upstream decode stage drives instruction fields, observes ALU operands
    modport master (
        output en, icode, ifun, valA, valB, valC,
        input  aluA, aluB, alufun, out_valid
    );

    // Operand selector consumes instruction fields, produces ALU operands
    modport slave (
        input  en, icode, ifun, valA, valB, valC,
        output aluA, aluB, alufun, out_valid
    );
endinterface

// File: rtl/execute_alu_operand_ctrl_mux.sv
// rtl/execute_alu_operand_ctrl_mux.sv - combinational icode/ifun decode of ALU operands and function
module alu_operand_mux
    import y86_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int STACK_STEP = 8
) (
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output alufun_e          alufun
);

    localparam logic [WIDTH-1:0] STEP_POS = WIDTH'(STACK_STEP);
    localparam logic [WIDTH-1:0] STEP_NEG = '0 - STEP_POS;

    // Operand/function decode; unlisted icodes fall through to zero / ADD
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alufun = ALU_ADD;
        case (icode)
            IRRMOVQ, IOPQ:            alu_a = valA;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = valC;
            ICALL, IPUSHQ:            alu_a = STEP_NEG;
            IRET, IPOPQ:              alu_a = STEP_POS;
            default:                  alu_a = '0;
        endcase
        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = valB;
            default:                                           alu_b = '0;
        endcase
        // Illegal OPq function codes silently execute as ADD
        if (icode == IOPQ && ifun < 4'd4) begin
            alufun = alufun_e'(ifun[1:0]);
        end
    end

endmodule

// File: rtl/execute_alu_operand_ctrl.sv
// rtl/execute_alu_operand_ctrl.sv - execute-stage ALU operand selector with stall-able output register
module execute_alu_operand_ctrl
    import y86_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int STACK_STEP = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    execute_alu_operand_ctrl_if.slave        bus
);

    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    alufun_e          mux_fun;

    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    alufun_e          alufun_q, alufun_d;
    logic             out_valid_q, out_valid_d;

    alu_operand_mux #(
        .WIDTH      (WIDTH),
        .STACK_STEP (STACK_STEP)
    ) u_mux (
        .icode  (bus.icode),
        .ifun   (bus.ifun),
        .valA   (bus.valA),
        .valB   (bus.valB),
        .valC   (bus.valC),
        .alu_a  (mux_a),
        .alu_b  (mux_b),
        .alufun (mux_fun)
    );

    // Capture the decoded selection when enabled, otherwise hold (stall)
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alufun_d    = alufun_q;
        out_valid_d = out_valid_q;
        if (bus.en) begin
            alu_a_d     = mux_a;
            alu_b_d     = mux_b;
            alufun_d    = mux_fun;
            out_valid_d = 1'b1;
        end
    end

    // Output register; reset clears immediately without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alufun_q    <= ALU_ADD;
            out_valid_q <= 1'b0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alufun_q    <= alufun_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.aluA      = alu_a_q;
    assign bus.aluB      = alu_b_q;
    assign bus.alufun    = alufun_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_execute_alu_operand_ctrl.sv
// tb/tb_execute_alu_operand_ctrl.sv - directed and randomized checks of execute_alu_operand_ctrl
module tb_execute_alu_operand_ctrl;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [1:0]  exp_fun;
    logic        exp_valid;

    execute_alu_operand_ctrl_if #(.WIDTH(64)) bus ();

    execute_alu_operand_ctrl #(.WIDTH(64), .STACK_STEP(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_a(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] c);
        if (ic == 4'h2 || ic == 4'h6) return a;
        if (ic >= 4'h3 && ic <= 4'h5) return c;
        if (ic == 4'h8 || ic == 4'hA) return 64'hFFFF_FFFF_FFFF_FFF8;
        if (ic == 4'h9 || ic == 4'hB) return 64'd8;
        return 64'd0;
    endfunction

    function automatic logic [63:0] ref_b(input logic [3:0] ic, input logic [63:0] b);
        if (ic >= 4'h4 && ic <= 4'hB && ic != 4'h7) return b;
        return 64'd0;
    endfunction

    function automatic logic [1:0] ref_fun(input logic [3:0] ic, input logic [3:0] fn);
        int f;
        f = int'(fn);
        if (ic == 4'h6 && f <= 3) return 2'(f);
        return 2'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".aluA"}, bus.aluA, exp_a);
        check({tag, ".aluB"}, bus.aluB, exp_b);
        check({tag, ".alufun"}, 64'(bus.alufun), 64'(exp_fun));
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(exp_valid));
    endtask

    task automatic drive(input logic e, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        bus.en    = e;
        bus.icode = ic;
        bus.ifun  = fn;
        bus.valA  = a;
        bus.valB  = b;
        bus.valC  = c;
    endtask

    // One clock edge, then advance the reference model and compare
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (rst_n && bus.en) begin
            exp_a     = ref_a(bus.icode, bus.valA, bus.valC);
            exp_b     = ref_b(bus.icode, bus.valB);
            exp_fun   = ref_fun(bus.icode, bus.ifun);
            exp_valid = 1'b1;
        end
        check_all(tag);
    endtask

    task automatic clear_model();
        exp_a     = '0;
        exp_b     = '0;
        exp_fun   = '0;
        exp_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] unused_ic [8];
        n_total = 0;
        n_pass  = 0;
        unused_ic = '{4'h0, 4'h1, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};

        rst_n = 1'b0;
        clear_model();
        drive(1'b1, 4'h6, 4'h0, 64'd30, 64'd50, 64'd0);
        tick("reset_hold0");
        tick("reset_hold1");
        #1 rst_n = 1'b1;

        for (int f = 0; f < 4; f++) begin
            drive(1'b1, 4'h6, 4'(f), 64'd30, 64'd50, 64'd0);
            tick($sformatf("opq_ifun%0d", f));
        end
        drive(1'b1, 4'h6, 4'h5, 64'd30, 64'd50, 64'd0);
        tick("opq_illegal");

        drive(1'b1, 4'h3, 4'h0, 64'd11, 64'd50, 64'd20); tick("irmovq");
        drive(1'b1, 4'h4, 4'h0, 64'd11, 64'd50, 64'd35); tick("rmmovq");
        drive(1'b1, 4'h5, 4'h0, 64'd11, 64'd50, 64'd70); tick("mrmovq");
        drive(1'b1, 4'h2, 4'h0, 64'd30, 64'd50, 64'd77); tick("rrmovq");

        drive(1'b1, 4'hA, 4'h0, 64'd30, 64'd50, 64'd5); tick("pushq");
        drive(1'b1, 4'h8, 4'h0, 64'd30, 64'd50, 64'd5); tick("call");
        drive(1'b1, 4'hB, 4'h0, 64'd30, 64'd50, 64'd5); tick("popq");
        drive(1'b1, 4'h9, 4'h0, 64'd30, 64'd50, 64'd5); tick("ret");

        drive(1'b1, 4'h6, 4'h1, 64'd30, 64'd50, 64'd0); tick("stall_load");
        drive(1'b0, 4'h3, 4'h0, 64'd30, 64'd50, 64'd99);
        for (int i = 0; i < 3; i++) tick($sformatf("stall_hold%0d", i));
        bus.en = 1'b1;
        tick("stall_release");

        for (int i = 0; i < 7; i++) begin
            drive(1'b1, unused_ic[i], 4'h3, 64'hDEAD, 64'hBEEF, 64'hCAFE);
            tick($sformatf("unused_ic%0h", unused_ic[i]));
        end

        drive(1'b1, 4'h6, 4'h2, 64'd123, 64'd456, 64'd0);
        tick("pre_async");
        rst_n = 1'b0;
        #1;
        clear_model();
        check_all("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
